mdio_drv: RTL and testbench

- Clause-22 MDIO master serial engine. It is the execution end of the management op handshake issued by mdio_ctrl.
- Accepts one op (read/write, register address, write data), serialises the 64-bit MDIO frame on MDC/MDIO to the PHY, and captures read data and the PHY turnaround acknowledge.
- Returns a single-cycle completion pulse.
- Sits between mdio_ctrl and the top-level MDIO IOBUF.

---
 rtl/mdio_drv.sv | 185 ++++++++++++++++++
 tb/tb_mdio_drv.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_drv.sv
// Clause-22 MDIO master: serialises one management op per request and returns read data and the PHY acknowledge.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble after the first completed op since reset.
module mdio_drv #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         CLK_DIV  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_exec,
    input  logic        op_rh_wl,
    input  logic [4:0]  op_addr,
    input  logic [15:0] op_wr_data,
    output logic        op_done,
    output logic        op_rd_ack,
    output logic [15:0] op_rd_data,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_reg;
    logic [7:0]  div_cnt_reg;
    logic [4:0]  bit_cnt_reg;
    logic        is_read_reg;
    logic [31:0] tx_sh_reg;
    logic [15:0] rx_sh_reg;
    logic        ack_smp_reg;
    logic        mdc_reg;
    logic        mdio_o_reg;
    logic        mdio_oe_reg;
    logic        op_done_reg;
    logic        op_rd_ack_reg;
    logic [15:0] op_rd_data_reg;
    logic        skip_pre;

    // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA. Read TA/DATA slots are
    // filled with ones so the released line idles high.
    logic [31:0] frame_hdr;
    assign frame_hdr = {2'b01,
                        (op_rh_wl ? 2'b10 : 2'b01),
                        PHY_ADDR,
                        op_addr,
                        (op_rh_wl ? 2'b11 : 2'b10),
                        (op_rh_wl ? 16'hFFFF : op_wr_data)};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic skip_pre_reg;
    assign skip_pre = skip_pre_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip_pre_reg <= 1'b0;
        end else if (state_reg == S_DONE) begin
            skip_pre_reg <= 1'b1;
        end
    end
`else
    assign skip_pre = 1'b0;
`endif

    // Segment bookkeeping evaluated at the end of every bit period.
    logic [4:0]  seg_last;
    state_t      seg_after;
    logic        bit_last;
    state_t      state_next;
    logic [31:0] tx_sh_next;
    logic        mdio_o_next;
    logic        mdio_oe_next;

    always_comb begin
        seg_last  = 5'd0;
        seg_after = S_IDLE;
        case (state_reg)
            S_PRE:   begin seg_last = 5'd31; seg_after = S_HDR;  end
            S_HDR:   begin seg_last = 5'd13; seg_after = S_TA;   end
            S_TA:    begin seg_last = 5'd1;  seg_after = S_DATA; end
            S_DATA:  begin seg_last = 5'd15; seg_after = S_DONE; end
            default: begin seg_last = 5'd0;  seg_after = S_IDLE; end
        endcase
        bit_last     = (bit_cnt_reg == seg_last);
        state_next   = bit_last ? seg_after : state_reg;
        tx_sh_next   = (state_reg == S_PRE) ? tx_sh_reg : {tx_sh_reg[30:0], 1'b1};
        mdio_o_next  = (state_next == S_PRE) ? 1'b1 : tx_sh_next[31];
        mdio_oe_next = (state_next == S_PRE) || (state_next == S_HDR) || !is_read_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            div_cnt_reg    <= 8'd0;
            bit_cnt_reg    <= 5'd0;
            is_read_reg    <= 1'b0;
            tx_sh_reg      <= 32'h0;
            rx_sh_reg      <= 16'h0;
            ack_smp_reg    <= 1'b0;
            mdc_reg        <= 1'b0;
            mdio_o_reg     <= 1'b1;
            mdio_oe_reg    <= 1'b0;
            op_done_reg    <= 1'b0;
            op_rd_ack_reg  <= 1'b0;
            op_rd_data_reg <= 16'h0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (op_exec) begin
                        is_read_reg <= op_rh_wl;
                        tx_sh_reg   <= frame_hdr;
                        div_cnt_reg <= 8'd0;
                        bit_cnt_reg <= 5'd0;
                        mdc_reg     <= 1'b0;
                        mdio_oe_reg <= 1'b1;
                        if (skip_pre) begin
                            state_reg  <= S_HDR;
                            mdio_o_reg <= frame_hdr[31];
                        end else begin
                            state_reg  <= S_PRE;
                            mdio_o_reg <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    op_done_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: begin
                    if (div_cnt_reg != DIV_LAST) begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end else begin
                        div_cnt_reg <= 8'd0;
                        if (!mdc_reg) begin
                            // Rising MDC: the line is sampled here.
                            mdc_reg <= 1'b1;
                            if (state_reg == S_TA && bit_cnt_reg == 5'd1) begin
                                ack_smp_reg <= mdio_i;
                            end
                            if (state_reg == S_DATA) begin
                                rx_sh_reg <= {rx_sh_reg[14:0], mdio_i};
                            end
                        end else begin
                            // Falling MDC: the next bit is launched.
                            mdc_reg     <= 1'b0;
                            tx_sh_reg   <= tx_sh_next;
                            state_reg   <= state_next;
                            bit_cnt_reg <= bit_last ? 5'd0 : bit_cnt_reg + 5'd1;
                            if (state_next == S_DONE) begin
                                mdio_o_reg  <= 1'b1;
                                mdio_oe_reg <= 1'b0;
                                op_done_reg <= 1'b1;
                                if (is_read_reg) begin
                                    op_rd_ack_reg  <= ack_smp_reg;
                                    op_rd_data_reg <= rx_sh_reg;
                                end else begin
                                    op_rd_ack_reg  <= 1'b0;
                                end
                            end else begin
                                mdio_o_reg  <= mdio_o_next;
                                mdio_oe_reg <= mdio_oe_next;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign op_done    = op_done_reg;
    assign op_rd_ack  = op_rd_ack_reg;
    assign op_rd_data = op_rd_data_reg;
    assign mdc        = mdc_reg;
    assign mdio_o     = mdio_o_reg;
    assign mdio_oe    = mdio_oe_reg;

endmodule

// File: tb/tb_mdio_drv.sv
// Bench for mdio_drv: table vectors, randomized ops against a frame-level model, and reset/overlap corner cases.
module tb_mdio_drv;

    localparam int         CLK_DIV  = 10;
    localparam logic [4:0] PHY_ADDR = 5'd1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_exec = 1'b0;
    logic        op_rh_wl = 1'b0;
    logic [4:0]  op_addr = 5'd0;
    logic [15:0] op_wr_data = 16'h0;
    logic        op_done;
    logic        op_rd_ack;
    logic [15:0] op_rd_data;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    mdio_drv #(.PHY_ADDR(PHY_ADDR), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_exec    (op_exec),
        .op_rh_wl   (op_rh_wl),
        .op_addr    (op_addr),
        .op_wr_data (op_wr_data),
        .op_done    (op_done),
        .op_rd_ack  (op_rd_ack),
        .op_rd_data (op_rd_data),
        .mdc        (mdc),
        .mdio_o     (mdio_o),
        .mdio_oe    (mdio_oe),
        .mdio_i     (mdio_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // PHY model and line monitor: records each bit at the first MDC-high cycle
    // and presents the PHY's next bit right after that rise.
    bit          phy_rd = 1'b0;
    bit          phy_present = 1'b0;
    logic [15:0] phy_data = 16'h0;
    int          phy_len = 64;
    int          rise_cnt = 0;
    int          rise_base = 0;
    int          cur_idx;
    logic        mdc_prev = 1'b0;
    logic        cap_o  [0:63];
    logic        cap_oe [0:63];
    int          rise_cyc [0:63];

    assign cur_idx = rise_cnt - rise_base;

    function automatic logic phy_bit(input int idx);
        if (!phy_rd || !phy_present) return 1'b1;
        if (idx == phy_len - 17) return 1'b0;
        if (idx >= phy_len - 16 && idx < phy_len) return phy_data[phy_len - 1 - idx];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (mdc && !mdc_prev) begin
            if (cur_idx >= 0 && cur_idx < 64) begin
                cap_o[cur_idx]    <= mdio_o;
                cap_oe[cur_idx]   <= mdio_oe;
                rise_cyc[cur_idx] <= cyc;
            end
            rise_cnt <= rise_cnt + 1;
            mdio_i   <= phy_bit(cur_idx + 1);
        end
        mdc_prev <= mdc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference state: what op_rd_ack/op_rd_data should hold and whether a preamble is due.
    bit          first_model = 1'b1;
    bit          model_ack = 1'b0;
    logic [15:0] model_data = 16'h0;

    task automatic run_op(input bit rd, input logic [4:0] addr, input logic [15:0] wd,
                          input bit present, input logic [15:0] pd,
                          input bit exp_ack, input logic [15:0] exp_data, input bit stray);
        int t_acc;
        int lat;
        int n_done;
        int len;
        int got_n;
        bit seen;
        logic [63:0] full;
        logic [63:0] m_full;
        logic [63:0] exp_v;
        logic [63:0] exp_m;
        logic [63:0] got_v;
        logic [63:0] got_m;
        len = (SUPPRESS && !first_model) ? 32 : 64;
        @(posedge clk); #1;
        phy_rd = rd; phy_present = present; phy_data = pd; phy_len = len;
        rise_base = rise_cnt;
        op_exec = 1'b1; op_rh_wl = rd; op_addr = addr; op_wr_data = wd;
        t_acc = cyc;
        n_done = 0; seen = 1'b0; lat = 0;
        @(negedge clk);
        if (op_done) n_done++;
        @(posedge clk); #1;
        op_exec = 1'b0;
        op_rh_wl = 1'($urandom); op_addr = 5'($urandom); op_wr_data = 16'($urandom);
        for (int i = 0; i < 140 * CLK_DIV && !seen; i++) begin
            @(negedge clk);
            op_exec = stray && (cyc == t_acc + 50);
            if (op_done) begin
                n_done++;
                seen = 1'b1;
                lat = cyc - t_acc;
            end
        end
        op_exec = 1'b0;
        got_n = rise_cnt - rise_base;
        full   = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, addr,
                  (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
        m_full = rd ? {{46{1'b1}}, {18{1'b0}}} : {64{1'b1}};
        exp_v  = (len == 32) ? {32'h0, full[31:0]} : full;
        exp_m  = (len == 32) ? {32'h0, m_full[31:0]} : m_full;
        got_v = 64'h0;
        got_m = 64'h0;
        for (int i = 0; i < len && i < got_n; i++) begin
            got_v[len - 1 - i] = cap_o[i];
            got_m[len - 1 - i] = cap_oe[i];
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(1 + 2 * len * CLK_DIV));
        chk("done_count", 64'(n_done), 64'd1);
        chk("frame_len", 64'(got_n), 64'(len));
        chk("frame_oe", got_m, exp_m);
        chk("frame_bits", got_v & exp_m, exp_v & exp_m);
        chk("mdc_span", 64'(rise_cyc[len - 1] - rise_cyc[0]), 64'((len - 1) * 2 * CLK_DIV));
        chk("first_rise", 64'(rise_cyc[0] - t_acc), 64'(1 + CLK_DIV));
        chk("rd_ack", 64'(op_rd_ack), 64'(exp_ack));
        chk("rd_data", 64'(op_rd_data), 64'(exp_data));
        $display("op rd=%0d addr=%h wd=%h phy=%0d pd=%h len=%0d lat=%0d ack=%0d data=%h",
                 rd, addr, wd, present, pd, len, lat, op_rd_ack, op_rd_data);
        first_model = 1'b0;
        model_ack   = exp_ack;
        model_data  = exp_data;
    endtask

    typedef struct {
        bit          rd;
        logic [4:0]  addr;
        logic [15:0] wd;
        bit          present;
        logic [15:0] pd;
        bit          exp_ack;
        logic [15:0] exp_data;
        bit          stray;
    } vec_t;

    vec_t tbl [0:4];

    initial begin
        bit          r_rd;
        bit          r_pr;
        logic [4:0]  r_addr;
        logic [15:0] r_wd;
        logic [15:0] r_pd;
        int          n_late;
        bit          reached;

        tbl[0] = '{rd: 1'b0, addr: 5'h00, wd: 16'h9140, present: 1'b0, pd: 16'h0000, exp_ack: 1'b0, exp_data: 16'h0000, stray: 1'b0};
        tbl[1] = '{rd: 1'b1, addr: 5'h01, wd: 16'h0000, present: 1'b1, pd: 16'h796D, exp_ack: 1'b0, exp_data: 16'h796D, stray: 1'b0};
        tbl[2] = '{rd: 1'b1, addr: 5'h1F, wd: 16'h0000, present: 1'b0, pd: 16'h0000, exp_ack: 1'b1, exp_data: 16'hFFFF, stray: 1'b0};
        tbl[3] = '{rd: 1'b0, addr: 5'h12, wd: 16'hA5C3, present: 1'b0, pd: 16'h0000, exp_ack: 1'b0, exp_data: 16'hFFFF, stray: 1'b1};
        tbl[4] = '{rd: 1'b1, addr: 5'h0A, wd: 16'h0000, present: 1'b1, pd: 16'h0001, exp_ack: 1'b0, exp_data: 16'h0001, stray: 1'b0};

        // Reset state, both while held and just after release.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_mdio_o", 64'(mdio_o), 64'd1);
        chk("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        chk("rst_done", 64'(op_done), 64'd0);
        chk("rst_ack", 64'(op_rd_ack), 64'd0);
        chk("rst_data", 64'(op_rd_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_levels", 64'({mdc, mdio_o, mdio_oe, op_done}), 64'b0100);

        for (int v = 0; v < 5; v++) begin
            run_op(tbl[v].rd, tbl[v].addr, tbl[v].wd, tbl[v].present, tbl[v].pd,
                   tbl[v].exp_ack, tbl[v].exp_data, tbl[v].stray);
        end

        for (int k = 0; k < 6; k++) begin
            r_rd = 1'($urandom); r_pr = 1'($urandom);
            r_addr = 5'($urandom); r_wd = 16'($urandom); r_pd = 16'($urandom);
            if (r_rd) run_op(r_rd, r_addr, r_wd, r_pr, r_pd, !r_pr, r_pr ? r_pd : 16'hFFFF, 1'b0);
            else      run_op(r_rd, r_addr, r_wd, r_pr, r_pd, 1'b0, model_data, 1'b0);
        end

        // Reset pulse in the middle of a read's data phase.
        @(posedge clk); #1;
        phy_rd = 1'b1; phy_present = 1'b1; phy_data = 16'h1234;
        phy_len = (SUPPRESS && !first_model) ? 32 : 64;
        rise_base = rise_cnt;
        op_exec = 1'b1; op_rh_wl = 1'b1; op_addr = 5'h03;
        @(posedge clk); #1;
        op_exec = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 140 * CLK_DIV && !reached; i++) begin
            @(negedge clk);
            if (rise_cnt - rise_base >= phy_len - 8) reached = 1'b1;
        end
        chk("reach_data", 64'(reached), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 64'({mdc, mdio_o, mdio_oe, op_done, op_rd_ack}), 64'b01000);
        chk("midrst_data", 64'(op_rd_data), 64'd0);
        n_late = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (op_done) n_late++;
        end
        chk("midrst_no_done", 64'(n_late), 64'd0);
        first_model = 1'b1; model_ack = 1'b0; model_data = 16'h0;

        run_op(1'b1, 5'h02, 16'h0, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
        run_op(1'b1, 5'h03, 16'h0, 1'b1, 16'h0F3C, 1'b0, 16'h0F3C, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
